bin_to_gray_reg: RTL and testbench
==================================

Name: bin_to_gray_reg

Overview:
- Registered binary-to-Gray-code encoder for counter/pointer values.
- Typical use: encoding FIFO read/write pointers before they cross clock domains, or before they are used as Gray-ordered memory addresses.
- Provides a one-cycle-latency Gray output plus a registered flag that marks any update changing more than one Gray bit. Such an update means the binary input did not step by ±1, which makes the value unsafe for CDC.

Parameters:
- CNTR_WIDTH, 4, width of the binary input and the Gray output in bits; legal range 1..32.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- binary_i  input  CNTR_WIDTH  unsigned binary counter value to encode.
- gray_code_o  output  CNTR_WIDTH  registered Gray encoding of binary_i.
- jump_err_o  output  1  registered; high when the latest update changed more than one bit of gray_code_o.

Behaviour:
- Encoding: gray_next = binary_i XOR (binary_i >> 1), logical shift. The MSB passes through unchanged, and bit k = b[k] XOR b[k+1] for k < CNTR_WIDTH-1.
- Latency: exactly 1 clk. gray_code_o at edge n+1 reflects binary_i sampled at edge n. There is no enable, so the output updates every cycle.
- Reset: when reset=1 at a rising edge, gray_code_o <= 0 and jump_err_o <= 0. Reset overrides any binary_i value. Reset asserted mid-operation clears both outputs on the next edge. The first edge after reset deasserts resumes normal encoding.
- jump_err_o, every non-reset edge: jump_err_o <= (popcount(gray_next XOR gray_code_o) > 1).
  - It is aligned with the same edge that loads gray_code_o, so it qualifies the value currently on gray_code_o.
  - Zero-bit change (binary_i held) -> 0.
  - One-bit change (increment or decrement by 1, including wrap all-ones -> 0 and 0 -> all-ones) -> 0.
- The first update after reset compares against 0. For example, 0 -> 1 gives 0, while 0 -> 2 (Gray 0011) gives 1.
- Width: no truncation or overflow; all operations are CNTR_WIDTH bits.
- CNTR_WIDTH=1: gray equals binary, and jump_err_o is always 0.
- Outputs are driven directly from flops; there is no combinational path from input to output.
- No X propagation after reset: both outputs are defined from the first reset edge onward.

Decomposition:
- Shared package gray_pkg:
  - function bin2gray(value, width-generic via a parameterised class or a max-width argument);
  - function gray2bin (prefix XOR from MSB);
  - function popcount_gt1.
- The RTL uses bin2gray and popcount_gt1. The bench uses gray2bin for its scoreboard.
- Optional sub-module gray_to_bin: combinational inverse, instantiated only in verification to round-trip gray_code_o back to binary.

Test Plan:
- Reset: hold reset=1 for 2 edges with binary_i=4'hF -> gray_code_o=4'b0000, jump_err_o=0.
- Known encodings, CNTR_WIDTH=4, one-cycle latency checked:
  - binary_i=5 -> gray_code_o=4'b0111 one edge later;
  - binary_i=10 -> 4'b1111;
  - binary_i=15 -> 4'b1000.
- Count sequence: binary_i increments 0..15 then wraps to 0 -> every successive gray_code_o differs in exactly one bit; 15->0 gives 4'b1000 -> 4'b0000; jump_err_o stays 0; gray2bin(gray_code_o) equals binary_i delayed by 1.
- Jump detection: from steady binary_i=0, drive 5 -> gray_code_o=4'b0111 and jump_err_o=1 on the same edge. Holding 5 -> jump_err_o=0 next edge. Stepping 5->4 (0111->0110) -> jump_err_o=0.
- Reset mid-run: counting, reset pulsed for 1 cycle while binary_i=9 -> outputs 0/0 next edge. Then with binary_i=10 -> gray_code_o=4'b1111 and jump_err_o=1, because it is compared against 0.
- Parameter sweep: CNTR_WIDTH=1 and 8.
  - Width 8: binary_i=8'hFF -> 8'h80; 8'h80 -> 8'hC0.
  - Width 1: output follows input with jump_err_o=0.

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : gray_pkg                                                   |
// | Brief   : Shared Gray-code helpers (encode, decode, multi-bit test). |
// |           All helpers work on a 32-bit container. Values narrower    |
// |           than 32 bits must be zero-extended before the call.        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package gray_pkg;

  localparam int c_MAX_WIDTH = 32;

  // Binary to Gray. With the upper bits zero-extended, the logical shift
  // passes the MSB of the real width through unchanged.
  function automatic logic [c_MAX_WIDTH-1:0] bin2gray(
    input logic [c_MAX_WIDTH-1:0] value
  );
    return value ^ (value >> 1);
  endfunction

  // Gray to binary. This is a prefix XOR taken from the MSB downward.
  function automatic logic [c_MAX_WIDTH-1:0] gray2bin(
    input logic [c_MAX_WIDTH-1:0] gray
  );
    logic [c_MAX_WIDTH-1:0] bin;
    bin = '0;
    bin[c_MAX_WIDTH-1] = gray[c_MAX_WIDTH-1];
    for (int i = c_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // True when more than one bit is set. Clearing the lowest set bit
  // leaves a non-zero value only if another bit was set.
  function automatic logic popcount_gt1(
    input logic [c_MAX_WIDTH-1:0] value
  );
    return (value & (value - 32'd1)) != 32'd0;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/bin_to_gray_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bin_to_gray_reg                                            |
// | Brief   : Registered binary-to-Gray encoder for counter/pointer      |
// |           values. Produces a one-cycle-latency Gray output plus a    |
// |           flag that marks any update changing more than one Gray     |
// |           bit. Such an update is unsafe to pass across a clock       |
// |           domain.                                                    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bin_to_gray_reg
  import gray_pkg::*;
#(
  parameter int CNTR_WIDTH = 4  // legal range 1..32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNTR_WIDTH-1:0] binary_i,
  output logic [CNTR_WIDTH-1:0] gray_code_o,
  output logic                  jump_err_o
);

  logic [CNTR_WIDTH-1:0] gray_code_q;
  logic [CNTR_WIDTH-1:0] gray_code_d;
  logic                  jump_err_q;
  logic                  jump_err_d;

  // Next-state logic: encode the input, then flag a multi-bit change
  // against the value currently on the output.
  always_comb begin
    gray_code_d = CNTR_WIDTH'(bin2gray(32'(binary_i)));
    jump_err_d  = popcount_gt1(32'(gray_code_d ^ gray_code_q));
  end

  // State registers. Reset forces a known zero code and a clear flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      gray_code_q <= '0;
      jump_err_q  <= 1'b0;
    end else begin
      gray_code_q <= gray_code_d;
      jump_err_q  <= jump_err_d;
    end
  end

  // Outputs come straight from flops, so no input-to-output path exists.
  assign gray_code_o = gray_code_q;
  assign jump_err_o  = jump_err_q;

endmodule : bin_to_gray_reg
`default_nettype wire

// File: tb/tb_bin_to_gray_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bin_to_gray_reg                                         |
// | Brief   : Self-checking bench for bin_to_gray_reg at widths 4, 1, 8. |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_bin_to_gray_reg;
  import gray_pkg::*;

  logic clk;
  logic rst4, rst1, rst8;
  logic [3:0] b4;
  logic [0:0] b1;
  logic [7:0] b8;
  logic [3:0] gray4;
  logic [0:0] gray1;
  logic [7:0] gray8;
  logic jump4, jump1, jump8;

  int n_checks;
  int n_fail;

  // Reference state for each instance.
  logic [31:0] eg4, eg1, eg8;
  logic        ej4, ej1, ej8;
  logic [31:0] last_b4;
  logic        rt_valid;
  int          ones_seen;

  bin_to_gray_reg #(.CNTR_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(rst4), .binary_i(b4), .gray_code_o(gray4), .jump_err_o(jump4));
  bin_to_gray_reg #(.CNTR_WIDTH(1)) u_dut1 (
    .clk(clk), .reset(rst1), .binary_i(b1), .gray_code_o(gray1), .jump_err_o(jump1));
  bin_to_gray_reg #(.CNTR_WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst8), .binary_i(b8), .gray_code_o(gray8), .jump_err_o(jump8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Report one comparison.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the Gray code by definition, and the error flag
  // as "more than one bit differs from the previous code".
  function automatic void model_upd(input int w, input logic r, input logic [31:0] b,
                                    inout logic [31:0] g, inout logic j);
    logic [31:0] mask;
    logic [31:0] ng;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (r) begin
      g = 32'd0;
      j = 1'b0;
    end else begin
      ng = (b ^ (b >> 1)) & mask;
      j  = ($countones(ng ^ g) > 1);
      g  = ng;
    end
  endfunction

  // Advance one clock, update the models and compare every output.
  task automatic step();
    logic [31:0] cap_b4;
    logic        cap_r4;
    cap_b4 = 32'(b4);
    cap_r4 = rst4;
    @(posedge clk);
    model_upd(4, rst4, 32'(b4), eg4, ej4);
    model_upd(1, rst1, 32'(b1), eg1, ej1);
    model_upd(8, rst8, 32'(b8), eg8, ej8);
    last_b4  = cap_b4;
    rt_valid = !cap_r4;
    #1;
    check("gray4", 32'(gray4), eg4);
    check("jump4", 32'(jump4), 32'(ej4));
    check("gray1", 32'(gray1), eg1);
    check("jump1", 32'(jump1), 32'(ej1));
    check("gray8", 32'(gray8), eg8);
    check("jump8", 32'(jump8), 32'(ej8));
    if (rt_valid) check("roundtrip4", gray2bin(32'(gray4)), last_b4);
    else          check("rst_gray4", 32'(gray4), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    eg4 = 32'hDEAD; eg1 = 32'hDEAD; eg8 = 32'hDEAD;
    ej4 = 1'b1; ej1 = 1'b1; ej8 = 1'b1;
    last_b4 = 0; rt_valid = 0; ones_seen = 0;

    // Reset held for two edges with the input at all ones.
    rst4 = 1; rst1 = 1; rst8 = 1;
    b4 = 4'hF; b1 = 1'b1; b8 = 8'hFF;
    #1;
    step();
    step();
    check("reset_gray", 32'(gray4), 32'd0);
    check("reset_jump", 32'(jump4), 32'd0);

    // Steady 0, then jump to 5, hold 5, and step down to 4.
    rst4 = 0; rst1 = 0; rst8 = 0;
    b4 = 4'd0; b1 = 1'b0;
    step();
    b4 = 4'd5;  step(); check("enc5",  32'(gray4), 32'b0111); check("jump5", 32'(jump4), 32'd1);
    step();             check("hold5", 32'(jump4), 32'd0);
    b4 = 4'd4;  step(); check("enc4",  32'(gray4), 32'b0110); check("step54", 32'(jump4), 32'd0);
    b4 = 4'd10; step(); check("enc10", 32'(gray4), 32'b1111);
    b4 = 4'd15; step(); check("enc15", 32'(gray4), 32'b1000);

    // Width 8: 8'hFF gives 8'h80, then 8'h80 gives 8'hC0.
    b8 = 8'hFF; step(); check("enc8_ff", 32'(gray8), 32'h80);
    b8 = 8'h80; step(); check("enc8_80", 32'(gray8), 32'hC0);

    // Count 0..15 and wrap to 0. No step may raise the jump flag.
    b4 = 4'd0; step();
    for (int i = 1; i <= 16; i++) begin
      b4 = 4'(i);
      step();
      if (jump4) ones_seen++;
    end
    check("count_nojump", 32'(ones_seen), 32'd0);
    check("wrap_gray", 32'(gray4), 32'd0);

    // Mid-run reset while 9 is driven, then 10 compared against zero.
    for (int i = 1; i <= 8; i++) begin
      b4 = 4'(i);
      step();
    end
    rst4 = 1; b4 = 4'd9; step();
    check("midrst_gray", 32'(gray4), 32'd0);
    check("midrst_jump", 32'(jump4), 32'd0);
    rst4 = 0; b4 = 4'd10; step();
    check("postrst_gray", 32'(gray4), 32'b1111);
    check("postrst_jump", 32'(jump4), 32'd1);

    // Random stimulus mixing unit steps, holds, arbitrary jumps and resets.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       b4 = b4 + 4'd1;
        1:       b4 = b4 - 4'd1;
        2:       b4 = b4;
        default: b4 = 4'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       b8 = b8 + 8'd1;
        1:       b8 = b8 - 8'd1;
        default: b8 = 8'($urandom);
      endcase
      b1   = 1'($urandom);
      rst4 = ($urandom_range(0, 19) == 0);
      rst1 = ($urandom_range(0, 19) == 0);
      rst8 = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bin_to_gray_reg
`default_nettype wire
